xillybus_loopback_fifo: RTL and testbench
=========================================

# xillybus_loopback_fifo

User-side loopback endpoint for the 32-bit Xillybus stream pair. It sits on `bus_clk` next to `xillybus`, sinks the `user_w_write_32_*` stream into a synchronous FIFO and sources the `user_r_read_32_*` stream from it. It generates the read-side end-of-file when the host closes the write file and the FIFO drains, and it flushes on `quiesce` or when both files are closed.

## Interface
Parameters:
- `ADDR_W`, default 9: FIFO depth is 2^ADDR_W words (512).
- `DATA_W`, default 32: word width. Must match the read_32/write_32 stream width.

Ports:
- `bus_clk`  in  1: single clock for all logic.
- `trn_reset_n`  in  1: reset, asynchronous assert, active-low.
- `quiesce`  in  1: core quiesce. While high, the block flushes.
- `user_w_write_32_wren`  in  1: write strobe from core.
- `user_w_write_32_data`  in  DATA_W: write data.
- `user_w_write_32_full`  out  1: FIFO full.
- `user_w_write_32_open`  in  1: host write file open.
- `user_r_read_32_rden`  in  1: read strobe from core.
- `user_r_read_32_data`  out  DATA_W: read data, registered.
- `user_r_read_32_empty`  out  1: FIFO empty.
- `user_r_read_32_eof`  out  1: end-of-file to host.
- `user_r_read_32_open`  in  1: host read file open.
- `fill_level`  out  ADDR_W+1: words currently stored, 0..2^ADDR_W.
- `overflow_err`  out  1: sticky; a write was attempted while full.
- `underflow_err`  out  1: sticky; a read was attempted while empty.

## Operation
- Storage is a 2^ADDR_W x DATA_W RAM. `wr_ptr` and `rd_ptr` are ADDR_W+1 bits and wrap modulo 2^(ADDR_W+1).
- empty = pointers equal. full = MSBs differ and the lower ADDR_W bits are equal. `fill_level` = wr_ptr − rd_ptr, modulo 2^(ADDR_W+1).
- Write accepted = wren && !full. On acceptance, mem[wr_ptr[ADDR_W-1:0]] is written and wr_ptr increments. A wren while full is dropped and sets `overflow_err`.
- Read accepted = rden && !empty. On acceptance, `user_r_read_32_data` is loaded with mem[rd_ptr] and rd_ptr increments. A rden while empty is dropped, sets `underflow_err`, and leaves the data output unchanged.
- full and empty are sampled at the start of the cycle, with no bypass:
  - wren+rden while empty: the write is accepted and the read is an underflow.
  - wren+rden while full: the read is accepted and the write is an overflow.
  - wren+rden otherwise: both are accepted and the fill level is unchanged.
- Flush condition = quiesce || (!user_w_write_32_open && !user_r_read_32_open).
  - At the next edge, both pointers go to 0.
  - wren/rden in that cycle are ignored and raise no error flags.
  - The data output holds its value.
- `overflow_err` and `underflow_err` are cleared only by reset or by `quiesce`, not by a file-close flush.
- EOF state machine:
  - IDLE → WRITING on `user_w_write_32_open` = 1.
  - WRITING → DRAINING on `user_w_write_32_open` = 0.
  - DRAINING → EOF when empty.
  - DRAINING or EOF → WRITING on `user_w_write_32_open` = 1.
  - Any state → IDLE on `user_r_read_32_open` = 0 or on quiesce. This has priority over every other transition.
- `user_r_read_32_eof` = (state == EOF). It is asserted only while empty = 1.

## Timing
- Reset values:
  - Pointers = 0 and `fill_level` = 0.
  - `user_r_read_32_data` = 0.
  - `user_w_write_32_full` = 0, `user_r_read_32_empty` = 1, `user_r_read_32_eof` = 0.
  - `overflow_err` = 0, `underflow_err` = 0.
  - State = IDLE.
- Read latency: data is valid on the edge after the accepting rden edge, as a standard FIFO (not first-word-fall-through).
- Write-to-visible latency: 1 cycle. empty deasserts the cycle after the accepting edge, and the word can be read with rden in that cycle.
- full, empty and `fill_level` are combinational from registered pointers and update one edge after the event.
- EOF asserts 1 cycle after entering DRAINING with empty, or 1 cycle after the last word is read in DRAINING.
- EOF deasserts 1 cycle after read-close, write-reopen or quiesce.
- Reset asserted mid-transfer: all state returns to reset values immediately, asynchronously. Deassertion is synchronous to `bus_clk` (synchronised externally).

## Test plan
- Reset, both files opened, write 3 words 0xA0..0xA2, then 3 rdens → data 0xA0, 0xA1, 0xA2, each one cycle after its rden; `fill_level` 3→0; empty = 1 afterwards; no error flags.
- Write 512 words with ADDR_W = 9 → full = 1, `fill_level` = 512. A 513th wren → `overflow_err` = 1 and the word is dropped. Read 512 → original sequence intact, including across the pointer wrap.
- rden while empty → `underflow_err` = 1, data holds its last value. wren+rden together while empty → `fill_level` = 1 and `underflow_err` = 1.
- Write 2 words, close the write file → eof stays 0. Read 2 words → eof = 1 one cycle after empty. Close the read file → eof = 0 and state = IDLE.
- Write 5 words, then pulse quiesce for 1 cycle → empty = 1, `fill_level` = 0, errors cleared, eof = 0. A subsequent write/read returns the new data only.
- Write 4 words, then assert `trn_reset_n` = 0 mid-burst without a clock edge → outputs take their reset values immediately.

Source files
------------

// File: rtl/xillybus_loopback_fifo.sv
// ---------------------------------------------------------------------------
// xillybus_loopback_fifo
//
// User-side loopback endpoint for the 32-bit Xillybus stream pair. Words
// written by the host on user_w_write_32 are stored in a synchronous FIFO
// and returned on user_r_read_32. The read side reports end-of-file once the
// host has closed the write file and the FIFO has drained. The FIFO is
// flushed on quiesce or when both files are closed.
//
// Ports:
//   bus_clk, trn_reset_n     clock; asynchronous active-low reset
//   quiesce                  core quiesce; flushes FIFO, clears error flags
//   user_w_write_32_*        write stream (wren, data in, full out, open)
//   user_r_read_32_*         read stream (rden, data out, empty/eof out, open)
//   fill_level               words currently stored, 0..2^ADDR_W
//   overflow_err             sticky: write attempted while full
//   underflow_err            sticky: read attempted while empty
// ---------------------------------------------------------------------------
module xillybus_loopback_fifo #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              bus_clk,
  input  logic              trn_reset_n,
  input  logic              quiesce,
  input  logic              user_w_write_32_wren,
  input  logic [DATA_W-1:0] user_w_write_32_data,
  output logic              user_w_write_32_full,
  input  logic              user_w_write_32_open,
  input  logic              user_r_read_32_rden,
  output logic [DATA_W-1:0] user_r_read_32_data,
  output logic              user_r_read_32_empty,
  output logic              user_r_read_32_eof,
  input  logic              user_r_read_32_open,
  output logic [ADDR_W:0]   fill_level,
  output logic              overflow_err,
  output logic              underflow_err
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRITING  = 2'd1,
    ST_DRAINING = 2'd2,
    ST_EOF      = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W+1){1'b0}};

  logic [DATA_W-1:0] mem_r [0:(2**ADDR_W)-1];
  logic [ADDR_W:0]   wr_ptr_r;
  logic [ADDR_W:0]   rd_ptr_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              overflow_r;
  logic              underflow_r;
  state_t            state_r;
  state_t            state_nxt_s;

  logic              empty_s;
  logic              full_s;
  logic              flush_s;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic              wr_drop_s;
  logic              rd_drop_s;

  // Status decode from the registered pointers; the extra MSB tells full from empty.
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]) &&
              (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]);
  end

  // Accept/drop decisions; a flushing cycle ignores both strobes without raising errors.
  always_comb begin
    flush_s   = quiesce || (!user_w_write_32_open && !user_r_read_32_open);
    wr_acc_s  = 1'b0;
    rd_acc_s  = 1'b0;
    wr_drop_s = 1'b0;
    rd_drop_s = 1'b0;
    if (flush_s) begin
      wr_acc_s  = 1'b0;
      rd_acc_s  = 1'b0;
    end else begin
      wr_acc_s  = user_w_write_32_wren && !full_s;
      rd_acc_s  = user_r_read_32_rden  && !empty_s;
      wr_drop_s = user_w_write_32_wren &&  full_s;
      rd_drop_s = user_r_read_32_rden  &&  empty_s;
    end
  end

  // Storage array write port (no reset: contents are don't-care until written).
  always_ff @(posedge bus_clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r[ADDR_W-1:0]] <= user_w_write_32_data;
    end
  end

  // Pointer registers: flush returns both to zero, otherwise advance on acceptance.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else if (flush_s) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Registered read data; holds its value on dropped reads and on flush.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (rd_acc_s) begin
      rd_data_r <= mem_r[rd_ptr_r[ADDR_W-1:0]];
    end
  end

  // Sticky error flags; only quiesce clears them, a file-close flush does not.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (quiesce) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r  || wr_drop_s;
      underflow_r <= underflow_r || rd_drop_s;
    end
  end

  // EOF state register.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // EOF next-state logic; read close or quiesce overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    if (!user_r_read_32_open || quiesce) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (user_w_write_32_open) state_nxt_s = ST_WRITING;
          else                      state_nxt_s = ST_IDLE;
        end
        ST_WRITING: begin
          if (!user_w_write_32_open) state_nxt_s = ST_DRAINING;
          else                       state_nxt_s = ST_WRITING;
        end
        ST_DRAINING: begin
          if (user_w_write_32_open) state_nxt_s = ST_WRITING;
          else if (empty_s)         state_nxt_s = ST_EOF;
          else                      state_nxt_s = ST_DRAINING;
        end
        ST_EOF: begin
          if (user_w_write_32_open) state_nxt_s = ST_WRITING;
          else                      state_nxt_s = ST_EOF;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Output mapping; eof is gated with empty so a stray write cannot leave it raised over data.
  always_comb begin
    user_w_write_32_full = full_s;
    user_r_read_32_empty = empty_s;
    user_r_read_32_data  = rd_data_r;
    user_r_read_32_eof   = (state_r == ST_EOF) && empty_s;
    fill_level           = wr_ptr_r - rd_ptr_r;
    overflow_err         = overflow_r;
    underflow_err        = underflow_r;
  end

endmodule

// File: tb/tb_xillybus_loopback_fifo.sv
// ---------------------------------------------------------------------------
// tb_xillybus_loopback_fifo
//
// Directed, self-checking bench for xillybus_loopback_fifo (ADDR_W = 9,
// DATA_W = 32). Inputs are driven 1 ns after each rising edge and outputs
// are checked at that same point, i.e. away from the active edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_xillybus_loopback_fifo;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2**ADDR_W;

  logic              bus_clk;
  logic              trn_reset_n;
  logic              quiesce;
  logic              w_wren;
  logic [DATA_W-1:0] w_data;
  logic              w_full;
  logic              w_open;
  logic              r_rden;
  logic [DATA_W-1:0] r_data;
  logic              r_empty;
  logic              r_eof;
  logic              r_open;
  logic [ADDR_W:0]   fill_level;
  logic              overflow_err;
  logic              underflow_err;

  int n_tests;
  int n_fail;

  xillybus_loopback_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .bus_clk              (bus_clk),
    .trn_reset_n          (trn_reset_n),
    .quiesce              (quiesce),
    .user_w_write_32_wren (w_wren),
    .user_w_write_32_data (w_data),
    .user_w_write_32_full (w_full),
    .user_w_write_32_open (w_open),
    .user_r_read_32_rden  (r_rden),
    .user_r_read_32_data  (r_data),
    .user_r_read_32_empty (r_empty),
    .user_r_read_32_eof   (r_eof),
    .user_r_read_32_open  (r_open),
    .fill_level           (fill_level),
    .overflow_err         (overflow_err),
    .underflow_err        (underflow_err)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1 ns after the rising edge.
  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    trn_reset_n = 1'b0;
    quiesce     = 1'b0;
    w_wren      = 1'b0;
    w_data      = 32'h0;
    w_open      = 1'b0;
    r_rden      = 1'b0;
    r_open      = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick();
    check("rst_empty", {63'd0, r_empty}, 64'd1);
    check("rst_full",  {63'd0, w_full},  64'd0);
    check("rst_fill",  {54'd0, fill_level}, 64'd0);
    check("rst_data",  {32'd0, r_data},  64'd0);
    check("rst_eof",   {63'd0, r_eof},   64'd0);
    check("rst_ovf",   {63'd0, overflow_err},  64'd0);
    check("rst_unf",   {63'd0, underflow_err}, 64'd0);
    trn_reset_n = 1'b1;
    w_open      = 1'b1;
    r_open      = 1'b1;
    tick();

    // ---------------- basic write 3 / read 3 ----------------
    for (int i = 0; i < 3; i++) begin
      w_wren = 1'b1;
      w_data = 32'hA0 + 32'(i);
      tick();
    end
    w_wren = 1'b0;
    check("basic_fill3",  {54'd0, fill_level}, 64'd3);
    check("basic_nempty", {63'd0, r_empty},    64'd0);
    r_rden = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("basic_rdata", {32'd0, r_data}, 64'hA0 + 64'(i));
    end
    r_rden = 1'b0;
    check("basic_fill0", {54'd0, fill_level}, 64'd0);
    check("basic_empty", {63'd0, r_empty},    64'd1);
    check("basic_ovf",   {63'd0, overflow_err},  64'd0);
    check("basic_unf",   {63'd0, underflow_err}, 64'd0);

    // ---------------- fill to full, overflow, drain across wrap ----------------
    for (int i = 0; i < DEPTH; i++) begin
      w_wren = 1'b1;
      w_data = 32'(i * 3 + 1);
      tick();
    end
    check("full_flag",   {63'd0, w_full},      64'd1);
    check("full_fill",   {54'd0, fill_level},  64'd512);
    check("full_noovf",  {63'd0, overflow_err}, 64'd0);
    w_data = 32'hDEAD_BEEF;
    tick();
    w_wren = 1'b0;
    check("ovf_flag",    {63'd0, overflow_err}, 64'd1);
    check("ovf_fill",    {54'd0, fill_level},   64'd512);
    r_rden = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      check("wrap_rdata", {32'd0, r_data}, 64'(i * 3 + 1));
    end
    r_rden = 1'b0;
    check("drain_empty", {63'd0, r_empty},       64'd1);
    check("drain_fill",  {54'd0, fill_level},    64'd0);
    check("drain_unf",   {63'd0, underflow_err}, 64'd0);

    // ---------------- underflow ----------------
    r_rden = 1'b1;
    tick();
    r_rden = 1'b0;
    check("unf_flag",    {63'd0, underflow_err}, 64'd1);
    check("unf_hold",    {32'd0, r_data},        64'd1534);
    quiesce = 1'b1;
    tick();
    quiesce = 1'b0;
    check("q_clr_ovf",   {63'd0, overflow_err},  64'd0);
    check("q_clr_unf",   {63'd0, underflow_err}, 64'd0);
    w_wren = 1'b1;
    r_rden = 1'b1;
    w_data = 32'h55;
    tick();
    w_wren = 1'b0;
    r_rden = 1'b0;
    check("wr_rd_empty_fill", {54'd0, fill_level},    64'd1);
    check("wr_rd_empty_unf",  {63'd0, underflow_err}, 64'd1);
    check("wr_rd_empty_hold", {32'd0, r_data},        64'd1534);
    r_rden = 1'b1;
    tick();
    r_rden = 1'b0;
    check("wr_rd_later_read", {32'd0, r_data}, 64'h55);

    // ---------------- EOF on write close + drain ----------------
    for (int i = 0; i < 2; i++) begin
      w_wren = 1'b1;
      w_data = 32'hB0 + 32'(i);
      tick();
    end
    w_wren = 1'b0;
    w_open = 1'b0;
    tick();
    check("eof_draining0", {63'd0, r_eof}, 64'd0);
    r_rden = 1'b1;
    tick();
    check("eof_rd0",   {32'd0, r_data}, 64'hB0);
    check("eof_mid",   {63'd0, r_eof},  64'd0);
    tick();
    r_rden = 1'b0;
    check("eof_rd1",   {32'd0, r_data}, 64'hB1);
    check("eof_empty", {63'd0, r_empty}, 64'd1);
    check("eof_notyet", {63'd0, r_eof}, 64'd0);
    tick();
    check("eof_set",   {63'd0, r_eof},  64'd1);
    r_open = 1'b0;
    tick();
    check("eof_rclose", {63'd0, r_eof}, 64'd0);
    check("close_keeps_unf", {63'd0, underflow_err}, 64'd1);
    tick();
    check("idle_no_eof", {63'd0, r_eof}, 64'd0);
    w_open = 1'b1;
    r_open = 1'b1;
    tick();

    // ---------------- quiesce flush ----------------
    for (int i = 0; i < 5; i++) begin
      w_wren = 1'b1;
      w_data = 32'hC0 + 32'(i);
      tick();
    end
    check("q_pre_fill", {54'd0, fill_level}, 64'd5);
    w_data  = 32'hEE;
    quiesce = 1'b1;
    tick();
    quiesce = 1'b0;
    w_wren  = 1'b0;
    check("q_empty", {63'd0, r_empty},       64'd1);
    check("q_fill",  {54'd0, fill_level},    64'd0);
    check("q_unf",   {63'd0, underflow_err}, 64'd0);
    check("q_ovf",   {63'd0, overflow_err},  64'd0);
    check("q_eof",   {63'd0, r_eof},         64'd0);
    w_wren = 1'b1;
    w_data = 32'hD0;
    tick();
    w_wren = 1'b0;
    r_rden = 1'b1;
    tick();
    r_rden = 1'b0;
    check("q_newdata",  {32'd0, r_data},  64'hD0);
    check("q_newempty", {63'd0, r_empty}, 64'd1);

    // ---------------- asynchronous reset mid-burst ----------------
    for (int i = 0; i < 4; i++) begin
      w_wren = 1'b1;
      w_data = 32'hE0 + 32'(i);
      tick();
    end
    check("ar_pre_fill", {54'd0, fill_level}, 64'd4);
    #2;
    trn_reset_n = 1'b0;
    w_wren      = 1'b0;
    #1;
    check("ar_fill",  {54'd0, fill_level}, 64'd0);
    check("ar_empty", {63'd0, r_empty},    64'd1);
    check("ar_full",  {63'd0, w_full},     64'd0);
    check("ar_data",  {32'd0, r_data},     64'd0);
    check("ar_eof",   {63'd0, r_eof},      64'd0);
    check("ar_ovf",   {63'd0, overflow_err},  64'd0);
    check("ar_unf",   {63'd0, underflow_err}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
